sram_lsu_port: RTL and testbench

- Load/store initiator that drives a single-port 4 KB word SRAM (1024 x 32, byte write enables, 1-cycle registered read) on behalf of the RV32 core's memory stage.
- Converts core-side byte/half/word requests (RISC-V funct3 encoding) into SRAM address, lane-aligned write data and byte enables.
- Extracts, aligns and sign- or zero-extends load data from the SRAM read word.
- Flags misaligned, out-of-window and illegal-size accesses as errors without touching the SRAM.

---
 rtl/sram_lsu_port.sv | 142 ++++++++++++++
 tb/tb_sram_lsu_port.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_lsu_port.sv
// Load/store port between the RV32 memory stage and a 1024x32 byte-enabled SRAM.
// Requests are decoded combinationally onto the SRAM pins; the response is held in a two-state FSM.
module sram_lsu_port #(
  parameter logic [19:0] BASE_ADDR = 20'h00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [9:0]  sram_a,
  output logic [31:0] sram_wd,
  output logic [3:0]  sram_wen,
  output logic        sram_cs,
  input  logic [31:0] sram_rd
);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t      state_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;

  logic        hs;
  logic        legal;
  logic        access;

  function automatic logic req_legal(input logic we, input logic [2:0] f3,
                                     input logic [31:0] addr);
    logic ok;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = ~addr[0];
      3'b010:  ok = (addr[1:0] == 2'b00);
      3'b100:  ok = ~we;
      3'b101:  ok = ~we & ~addr[0];
      default: ok = 1'b0;
    endcase
    return ok && (addr[31:12] == BASE_ADDR);
  endfunction

  function automatic logic [3:0] store_wen(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wd(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rd);
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] x_s;
    b_s = rd[8*off +: 8];
    h_s = rd[16*off[1] +: 16];
    x_s = rd;
    case (f3[1:0])
      2'b00: begin
        if (f3[2]) x_s = {24'd0, b_s};
        else       x_s = b_s;
      end
      2'b01: begin
        if (f3[2]) x_s = {16'd0, h_s};
        else       x_s = h_s;
      end
      default: x_s = rd;
    endcase
    return x_s;
  endfunction

  assign req_ready = (state_q == IDLE) && !rst;
  assign hs        = req_valid && req_ready;
  assign legal     = req_legal(req_we, req_funct3, req_addr);
  assign access    = hs && legal;

  // Request side: SRAM pins follow the accepted request in the same cycle
  assign sram_cs  = access;
  assign sram_a   = access ? req_addr[11:2] : 10'd0;
  assign sram_wen = (access && req_we) ? store_wen(req_funct3, req_addr[1:0]) : 4'd0;
  assign sram_wd  = (access && req_we) ? store_wd(req_funct3, req_wdata) : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      we_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hs) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= ~legal;
            we_q         <= req_we;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (hs) begin
      funct3_q <= req_funct3;
      off_q    <= req_addr[1:0];
    end
  end

  // Response side: sram_rd is stable in RESP since the SRAM is deselected
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = (resp_valid_q && !we_q && !resp_err_q)
                      ? load_ext(funct3_q, off_q, sram_rd) : 32'd0;

endmodule

// File: tb/tb_sram_lsu_port.sv
// Randomized bench for sram_lsu_port against a byte-array memory model.
module tb_sram_lsu_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [9:0]  sram_a;
  logic [31:0] sram_wd;
  logic [3:0]  sram_wen;
  logic        sram_cs;
  logic [31:0] sram_rd;

  int errs = 0;
  int checks = 0;

  logic [31:0] mem [0:1023];
  logic [7:0]  model_mem [0:4095];

  sram_lsu_port #(.BASE_ADDR(20'h00000)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .sram_a(sram_a), .sram_wd(sram_wd), .sram_wen(sram_wen), .sram_cs(sram_cs),
    .sram_rd(sram_rd)
  );

  always #5 clk = ~clk;

  // SRAM macro: byte-enabled write, registered read, both gated by chip select
  always @(posedge clk) begin
    if (sram_cs) begin
      for (int b = 0; b < 4; b++)
        if (sram_wen[b]) mem[sram_a][8*b +: 8] <= sram_wd[8*b +: 8];
      sram_rd <= mem[sram_a];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int m_size(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit m_legal(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    int n;
    if (addr[31:12] != 20'h00000) return 0;
    if (we && !(f3 inside {3'b000, 3'b001, 3'b010})) return 0;
    if (!we && !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 0;
    n = m_size(f3);
    return (addr % n) == 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr);
    int n;
    logic [31:0] v;
    n = m_size(f3);
    v = 32'd0;
    for (int i = 0; i < n; i++)
      v = v | (32'(model_mem[addr[11:0] + 12'(i)]) << (8*i));
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
    return v;
  endfunction

  function automatic logic [3:0] m_wen(input logic [2:0] f3, input logic [31:0] addr);
    logic [3:0] w;
    w = 4'd0;
    for (int i = 0; i < m_size(f3); i++) w[addr[1:0] + 2'(i)] = 1'b1;
    return w;
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    for (int l = 0; l < 4; l++) r[8*l +: 8] = wd[8*(l % m_size(f3)) +: 8];
    return r;
  endfunction

  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int stall,
                        output logic [31:0] rd_o, output logic err_o);
    bit lg;
    logic [31:0] exp_rd;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    #1;
    lg = m_legal(we, f3, addr);
    check("req_ready_idle", req_ready, 1);
    check("sram_cs", sram_cs, lg);
    check("sram_wen", sram_wen, (lg && we) ? m_wen(f3, addr) : 4'd0);
    if (lg) check("sram_a", sram_a, addr[11:2]);
    if (lg && we) check("sram_wd", sram_wd, m_wd(f3, wd));
    exp_rd = (lg && !we) ? m_load(f3, addr) : 32'd0;
    if (lg && we)
      for (int i = 0; i < m_size(f3); i++)
        model_mem[addr[11:0] + 12'(i)] = wd[8*i +: 8];
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("resp_valid", resp_valid, 1);
    check("resp_err", resp_err, !lg);
    check("resp_rdata", resp_rdata, exp_rd);
    check("req_ready_resp", req_ready, 0);
    rd_o = resp_rdata; err_o = resp_err;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      req_valid = (s == 1); req_we = 1'b1; req_funct3 = 3'b010;
      req_addr = {20'h00000, addr[11:2], 2'b00}; req_wdata = $urandom;
      #1;
      check("stall_cs", sram_cs, 0);
      check("stall_valid", resp_valid, 1);
      check("stall_rdata", resp_rdata, exp_rd);
      check("stall_err", resp_err, !lg);
      check("stall_ready", req_ready, 0);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = {20'h00000, addr[11:2], 2'b00}; req_wdata = $urandom;
    #1;
    check("resp_hs_cs", sram_cs, 0);
    check("resp_hs_rdata", resp_rdata, exp_rd);
    @(posedge clk); #1;
    resp_ready = 1'b0; req_valid = 1'b0;
    check("resp_drop", resp_valid, 0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [2:0]  f3;
    logic [31:0] a;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    for (int i = 0; i < 4096; i++) model_mem[i] = 8'd0;
    sram_rd = 32'd0;
    rst = 1'b1; resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h10; req_wdata = 32'h1;
    #12;
    check("rst_ready", req_ready, 0);
    check("rst_cs", sram_cs, 0);
    check("rst_wen", sram_wen, 0);
    check("rst_a", sram_a, 0);
    check("rst_wd", sram_wd, 0);
    check("rst_valid", resp_valid, 0);
    check("rst_rdata", resp_rdata, 0);
    check("rst_err", resp_err, 0);
    req_valid = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
    check("post_rst_ready", req_ready, 1);

    access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd, er);
    check("sw_rdata_zero", rd, 32'd0);
    access(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er);
    check("lw_deadbeef", rd, 32'hDEADBEEF);
    access(1'b1, 3'b000, 32'h13, 32'h80, 0, rd, er);
    access(1'b0, 3'b000, 32'h13, 32'h0, 0, rd, er);
    check("lb_sext", rd, 32'hFFFFFF80);
    access(1'b0, 3'b100, 32'h13, 32'h0, 0, rd, er);
    check("lbu_zext", rd, 32'h00000080);
    access(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er);
    check("lw_after_sb", rd, 32'h80ADBEEF);
    access(1'b1, 3'b001, 32'h12, 32'h12348001, 0, rd, er);
    access(1'b0, 3'b001, 32'h12, 32'h0, 0, rd, er);
    check("lh_sext", rd, 32'hFFFF8001);
    access(1'b0, 3'b101, 32'h12, 32'h0, 0, rd, er);
    check("lhu_zext", rd, 32'h00008001);

    access(1'b0, 3'b010, 32'h2, 32'h0, 0, rd, er);
    check("err_lw_misalign", er, 1);
    access(1'b1, 3'b001, 32'h1, 32'hFFFF, 0, rd, er);
    check("err_sh_misalign", er, 1);
    access(1'b1, 3'b100, 32'h20, 32'hFF, 0, rd, er);
    check("err_sb_f3", er, 1);
    access(1'b0, 3'b010, 32'h1000, 32'h0, 0, rd, er);
    check("err_window", er, 1);

    access(1'b0, 3'b010, 32'h10, 32'h0, 5, rd, er);
    check("stall_lw", rd, 32'h8001BEEF);
    access(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er);
    check("stall_no_write", rd, 32'h8001BEEF);

    // Reset while a load response is pending
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("pre_rst_valid", resp_valid, 1);
    #2 rst = 1'b1; #1;
    check("async_rst_valid", resp_valid, 0);
    check("async_rst_rdata", resp_rdata, 0);
    check("async_rst_ready", req_ready, 0);
    @(negedge clk); rst = 1'b0; #1;
    check("rst_idle_ready", req_ready, 1);
    check("rst_idle_valid", resp_valid, 0);
    access(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er);
    check("lw_after_rst", rd, 32'h8001BEEF);

    for (int n = 0; n < 400; n++) begin
      f3 = 3'($urandom_range(0, 7));
      a = {20'h00000, 6'd0, 6'($urandom)};
      if ($urandom_range(0, 1) == 1) a = a & ~32'(m_size(f3) - 1);
      if ($urandom_range(0, 15) == 0) a[31:12] = 20'($urandom);
      access(1'($urandom), f3, a, $urandom,
             ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0, rd, er);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
